// File: rtl/trap_ctrl_unit.sv
// Sequential trap controller beside the ID stage: synchronised, maskable, prioritised IRQs, undefined-
// instruction exceptions, EPC/cause capture and a USER -> FLUSH -> KERNEL mode sequence.
module trap_ctrl_unit #(
    parameter int unsigned     NIrq    = 4,
    parameter int unsigned     PcW     = 32,
    parameter int unsigned     SyncStg = 2,
    parameter logic [PcW-1:0]  IrqVec  = PcW'(32'h8000_0004),
    parameter logic [PcW-1:0]  ExcVec  = PcW'(32'h8000_0008),
    parameter logic [NIrq-1:0] MaskRst = {NIrq{1'b1}}
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NIrq-1:0] irq_in_i,
    input  logic            mask_we_i,
    input  logic [NIrq-1:0] mask_wdata_i,
    input  logic            id_valid_i,
    input  logic            id_stall_i,
    input  logic [PcW-1:0]  id_pc_i,
    input  logic            id_undefined_i,
    input  logic            id_eret_i,
    output logic            take_trap_o,
    output logic [PcW-1:0]  trap_pc_o,
    output logic [PcW-1:0]  epc_o,
    output logic [3:0]      cause_o,
    output logic            kernel_o,
    output logic [NIrq-1:0] irq_pending_o,
    output logic [NIrq-1:0] irq_mask_o,
    output logic            double_fault_o
);

    typedef enum logic [1:0] {StUser, StFlush, StKernel} state_e;

    state_e                       state_q, state_d;
    logic [SyncStg-1:0][NIrq-1:0] sync_q;
    logic [NIrq-1:0]              sync_dly_q;
    logic [NIrq-1:0]              pending_q, pending_d;
    logic [NIrq-1:0]              mask_q, mask_d;
    logic [PcW-1:0]               epc_q, epc_d;
    logic [3:0]                   cause_q, cause_d;
    logic                         kernel_q, kernel_d;
    logic                         dfault_q, dfault_d;

    logic [NIrq-1:0] irq_rise, eligible, irq_grant;
    logic [3:0]      irq_cause;
    logic            slot;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            sync_dly_q <= '0;
        end else begin
            sync_q     <= {sync_q[SyncStg-2:0], irq_in_i};
            sync_dly_q <= sync_q[SyncStg-1];
        end
    end

    assign irq_rise = sync_q[SyncStg-1] & ~sync_dly_q;
    assign eligible = pending_q & mask_q;
    // Isolate lowest set bit: lowest channel index has priority.
    assign irq_grant = eligible & (~eligible + NIrq'(1));
    assign slot      = id_valid_i & ~id_stall_i;

    always_comb begin
        irq_cause = 4'd0;
        for (int i = NIrq - 1; i >= 0; i--) begin
            if (irq_grant[i]) irq_cause = 4'(i) + 4'd2;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        mask_d      = mask_we_i ? mask_wdata_i : mask_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        kernel_d    = kernel_q;
        dfault_d    = dfault_q;
        take_trap_o = 1'b0;
        trap_pc_o   = '0;
        unique case (state_q)
            StUser: begin
                if (slot && id_undefined_i) begin
                    take_trap_o = 1'b1;
                    trap_pc_o   = ExcVec;
                    epc_d       = id_pc_i + PcW'(4);
                    cause_d     = 4'd1;
                    state_d     = StFlush;
                end else if (slot && (eligible != '0)) begin
                    take_trap_o = 1'b1;
                    trap_pc_o   = IrqVec;
                    epc_d       = id_pc_i;
                    cause_d     = irq_cause;
                    pending_d   = pending_q & ~irq_grant;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                kernel_d = 1'b1;
                state_d  = StKernel;
            end
            StKernel: begin
                if (slot && id_undefined_i) begin
                    take_trap_o = 1'b1;
                    trap_pc_o   = ExcVec;
                    dfault_d    = 1'b1;
                    state_d     = StFlush;
                end else if (slot && id_eret_i) begin
                    kernel_d = 1'b0;
                    state_d  = StUser;
                end
            end
            default: state_d = StUser;
        endcase
        // A new edge wins over a same-cycle acceptance clear.
        pending_d = pending_d | irq_rise;
        if (!rst_ni) begin
            take_trap_o = 1'b0;
            trap_pc_o   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StUser;
            pending_q <= '0;
            mask_q    <= MaskRst;
            epc_q     <= '0;
            cause_q   <= 4'd0;
            kernel_q  <= 1'b0;
            dfault_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            kernel_q  <= kernel_d;
            dfault_q  <= dfault_d;
        end
    end

    assign epc_o          = epc_q;
    assign cause_o        = cause_q;
    assign kernel_o       = kernel_q;
    assign irq_pending_o  = pending_q;
    assign irq_mask_o     = mask_q;
    assign double_fault_o = dfault_q;

endmodule

// File: tb/tb_trap_ctrl_unit.sv
// Randomised scoreboard bench for trap_ctrl_unit: a mode/pending reference model predicts every cycle's
// outputs, a monitor compares them mid-cycle; async resets (some mid-FLUSH) are checked directly.
module tb_trap_ctrl_unit;

    localparam int unsigned NIrq    = 4;
    localparam int unsigned SyncStg = 2;
    localparam logic [31:0] IrqVec  = 32'h8000_0004;
    localparam logic [31:0] ExcVec  = 32'h8000_0008;
    localparam int          NCyc    = 4000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NIrq-1:0] irq_in, mask_wdata;
    logic            mask_we, id_valid, id_stall, id_undefined, id_eret;
    logic [31:0]     id_pc;
    logic            take_trap, kernel, double_fault;
    logic [31:0]     trap_pc, epc;
    logic [3:0]      cause;
    logic [NIrq-1:0] irq_pending, irq_mask;

    trap_ctrl_unit dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .irq_in_i       (irq_in),
        .mask_we_i      (mask_we),
        .mask_wdata_i   (mask_wdata),
        .id_valid_i     (id_valid),
        .id_stall_i     (id_stall),
        .id_pc_i        (id_pc),
        .id_undefined_i (id_undefined),
        .id_eret_i      (id_eret),
        .take_trap_o    (take_trap),
        .trap_pc_o      (trap_pc),
        .epc_o          (epc),
        .cause_o        (cause),
        .kernel_o       (kernel),
        .irq_pending_o  (irq_pending),
        .irq_mask_o     (irq_mask),
        .double_fault_o (double_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            take;
        logic [31:0]     tpc;
        logic [31:0]     epc;
        logic [3:0]      cause;
        logic            kern;
        logic [NIrq-1:0] pend;
        logic [NIrq-1:0] mask;
        logic            df;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: "handler entered" is kernel bit; a trap always spends one flush cycle first.
    logic [31:0]     m_epc;
    logic [3:0]      m_cause;
    logic            m_kern, m_flush, m_df;
    logic [NIrq-1:0] m_pend, m_mask;
    logic [NIrq-1:0] hist[$];  // irq_in as sampled on each clock edge

    task automatic model_reset();
        m_epc = '0; m_cause = '0; m_kern = 1'b0; m_flush = 1'b0; m_df = 1'b0;
        m_pend = '0; m_mask = '1;
        hist.delete();
        for (int i = 0; i < SyncStg + 2; i++) hist.push_back('0);
    endtask

    task automatic model_decide(output bit take, output logic [31:0] tpc, output int k);
        bit slot;
        slot = id_valid && !id_stall;
        take = 1'b0; tpc = '0; k = -1;
        if (m_flush) return;
        if (slot && id_undefined) begin
            take = 1'b1; tpc = ExcVec;
        end else if (!m_kern && slot) begin
            for (int i = 0; i < NIrq; i++) begin
                if (k < 0 && m_pend[i] && m_mask[i]) k = i;
            end
            if (k >= 0) begin
                take = 1'b1; tpc = IrqVec;
            end
        end
    endtask

    task automatic model_edge();
        bit              t;
        logic [31:0]     p;
        int              k;
        logic [NIrq-1:0] rise;
        model_decide(t, p, k);
        if (m_flush) begin
            m_flush = 1'b0;
            m_kern  = 1'b1;
        end else if (t) begin
            m_flush = 1'b1;
            if (m_kern) m_df = 1'b1;
            else if (k < 0) begin
                m_epc = id_pc + 32'd4; m_cause = 4'd1;
            end else begin
                m_epc = id_pc; m_cause = 4'(k + 2); m_pend[k] = 1'b0;
            end
        end else if (m_kern && id_valid && !id_stall && id_eret) begin
            m_kern = 1'b0;
        end
        if (mask_we) m_mask = mask_wdata;
        hist.push_back(irq_in);
        rise = hist[hist.size() - 1 - SyncStg] & ~hist[hist.size() - 2 - SyncStg];
        m_pend = m_pend | rise;
        while (hist.size() > SyncStg + 2) void'(hist.pop_front());
    endtask

    task automatic drive_and_push();
        bit          t;
        logic [31:0] p;
        int          k;
        exp_t        e;
        for (int i = 0; i < NIrq; i++) if ($urandom_range(0, 11) == 0) irq_in[i] = ~irq_in[i];
        mask_we      = ($urandom_range(0, 19) == 0);
        mask_wdata   = NIrq'($urandom);
        id_valid     = ($urandom_range(0, 9) < 8);
        id_stall     = ($urandom_range(0, 4) == 0);
        id_undefined = ($urandom_range(0, 9) == 0);
        id_eret      = ($urandom_range(0, 3) == 0);
        id_pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        model_decide(t, p, k);
        e = '{take: t, tpc: p, epc: m_epc, cause: m_cause, kern: m_kern, pend: m_pend,
              mask: m_mask, df: m_df};
        sb.push_back(e);
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if (take_trap !== 1'b0 || trap_pc !== '0 || epc !== '0 || cause !== '0 || kernel !== 1'b0 ||
            irq_pending !== '0 || irq_mask !== '1 || double_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got take=%b tpc=%h epc=%h cause=%0d k=%b pend=%b mask=%b df=%b, want all 0, mask=1111",
                     name, take_trap, trap_pc, epc, cause, kernel, irq_pending, irq_mask, double_fault);
        end
    endtask

    // Monitor: every cycle the DUT presents a decision/state; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (take_trap !== e.take || (e.take && trap_pc !== e.tpc) || epc !== e.epc ||
                    cause !== e.cause || kernel !== e.kern || irq_pending !== e.pend ||
                    irq_mask !== e.mask || double_fault !== e.df) begin
                    n_bad++;
                    $display("FAIL vec%0d @%0t: got take=%b tpc=%h epc=%h cause=%0d k=%b pend=%b mask=%b df=%b; want take=%b tpc=%h epc=%h cause=%0d k=%b pend=%b mask=%b df=%b",
                             n_vec, $time, take_trap, trap_pc, epc, cause, kernel, irq_pending,
                             irq_mask, double_fault, e.take, e.tpc, e.epc, e.cause, e.kern, e.pend,
                             e.mask, e.df);
                end
            end
        end
    end

    initial begin
        int n_rst = 0;
        rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        id_valid = 1'b1; id_stall = 1'b0; id_undefined = 1'b1; id_eret = 1'b0; id_pc = 32'h100;
        model_reset();
        #12;
        check_reset("reset_init");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_and_push();
        for (int c = 0; c < NCyc; c++) begin
            @(posedge clk); #1;
            model_edge();
            if ((m_flush && n_rst < 4 && $urandom_range(0, 3) == 0) || c == NCyc / 2) begin
                n_rst++;
                #2 rst_n = 1'b0;
                #1 check_reset("reset_async");
                model_reset();
                @(posedge clk); #1;
                check_reset("reset_hold");
                rst_n = 1'b1;
            end
            drive_and_push();
        end
        @(negedge clk); #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
